gpio_ctrl: RTL and testbench
============================

Name: gpio_ctrl

Overview:
Parametrised GPIO controller on the peripheral local bus, a generalisation of the fixed 16-pin GPIO register block. It provides per-pin direction and output registers and atomic set/clear/toggle registers. Inputs pass through a multi-stage synchroniser, and per-pin rising/falling edge interrupts are latched into a write-1-to-clear status register. Pads are split into in/out/oe; tristate buffers live at chip top.

Parameters:
NUM_GPIO, 16, number of pins, legal 1..32; register bits at or above NUM_GPIO read 0 and ignore writes
SYNC_STAGES, 2, input synchroniser depth, legal 2..4

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
add_w  input  32  write byte address; only add_w[7:2] decoded
data_w  input  32  write data
wen  input  1  write strobe, one transfer per cycle
wmask  input  4  byte enables for data_w
wready  output  1  write acknowledge pulse
add_r  input  32  read byte address; only add_r[7:2] decoded
ren  input  1  read strobe
data_r  output  32  read data, valid while rvalid=1
rvalid  output  1  read-data-valid pulse
gpio_in  input  NUM_GPIO  raw pad inputs, asynchronous
gpio_out  output  NUM_GPIO  output register value
gpio_oe  output  NUM_GPIO  output enable, 1=drive
irq  output  1  interrupt, level, registered

Behaviour:
- Reset (async, rst=1): all registers 0, synchroniser and prev-sample flops 0, gpio_out=0, gpio_oe=0, irq=0, wready=0, rvalid=0, data_r=0, warm-up counter=0.
- Register map (offset, access):
  - 0x00 OUT, RW
  - 0x04 DIR, RW; drives gpio_oe
  - 0x08 IN, RO; synchronised input
  - 0x0C SET, WO; 1 sets OUT bit
  - 0x10 CLR, WO; 1 clears OUT bit
  - 0x14 TGL, WO; 1 inverts OUT bit
  - 0x18 RISE_EN, RW
  - 0x1C FALL_EN, RW
  - 0x20 STATUS, W1C
  - WO registers read 0. Unmapped offsets read 0 and ignore writes, but still handshake.
- Write: sampled at the rising edge where wen=1; register updates at that edge. wready=1 for exactly the following cycle. Back-to-back writes are accepted every cycle with no stall.
- wmask[i] gates byte i of data_w for every register type: RW, SET/CLR/TGL, and W1C. wmask=0 writes nothing but still acks.
- Read: add_r sampled at the edge where ren=1. data_r and rvalid=1 appear the next cycle (latency 1). rvalid lasts one cycle. data_r holds its last value when rvalid=0.
- Read and write to the same register in the same cycle: read returns the pre-write value.
- gpio_out = OUT and gpio_oe = DIR, both direct from flops. OUT updates regardless of DIR.
- Synchroniser: SYNC_STAGES flops per pin. IN = last stage. prev = IN delayed one cycle.
- Warm-up counter: counts 0..SYNC_STAGES+1 after reset, then saturates. Edge detection is suppressed until it saturates, so pins tied high at reset raise no interrupt.
- Edge detection (after warm-up):
  - rise = IN & ~prev & RISE_EN
  - fall = ~IN & prev & FALL_EN
  - Matching STATUS bits set at the clock edge.
  - A pin change before edge k sets STATUS at edge k+SYNC_STAGES and irq at edge k+SYNC_STAGES+1.
- STATUS W1C: written 1s clear bits. If a set event and a clear hit the same bit in the same cycle, set wins (bit stays 1).
- Clearing RISE_EN/FALL_EN does not clear already-latched STATUS bits.
- irq registered = |STATUS of the previous cycle. Deasserts one cycle after the last STATUS bit clears.
- Mid-operation reset: every state returns to reset values immediately. A pending rvalid/wready is dropped.

Test Plan:
- Reset/idle: assert rst mid-transfer -> gpio_out=0, gpio_oe=0, irq=0, wready=0, rvalid=0; all registers read 0x0.
- RW and masking: write OUT=0x0000A5A5 with wmask=4'b0001 -> wready next cycle; read OUT -> 0x000000A5 one cycle after ren; gpio_out=16'h00A5.
- Atomic ops: OUT=0x00F0, then SET 0x000F -> 0x00FF; CLR 0x0081 -> 0x007E; TGL 0xFFFF -> 0xFF81; back-to-back writes on consecutive cycles, 3 wready pulses.
- Interrupts: RISE_EN=0x0001, FALL_EN=0x0002; pulse gpio_in[0] up, drop gpio_in[1] -> STATUS=0x3 after SYNC_STAGES edges, irq one cycle later; write STATUS=0x1 -> STATUS=0x2, irq stays 1; write 0x2 -> irq=0 next cycle.
- Boundary: W1C to bit 0 in the same cycle as a new rising edge on pin 0 -> bit stays 1. gpio_in=all 1s through reset release -> STATUS stays 0. NUM_GPIO=5: write 0xFFFFFFFF to OUT -> read 0x0000001F.
- Unmapped/read-write collision: read 0x3C -> 0x0 with rvalid. Simultaneous read and write of OUT -> old value returned, new value on the next read.

Source files
------------

// File: rtl/gpio_ctrl_if.sv
// Peripheral local bus bundle for gpio_ctrl: one write channel and one read
// channel, each acknowledged by a single-cycle pulse.
`timescale 1ns/1ps

interface gpio_ctrl_if;
  logic [31:0] add_w;
  logic [31:0] data_w;
  logic        wen;
  logic [3:0]  wmask;
  logic        wready;
  logic [31:0] add_r;
  logic        ren;
  logic [31:0] data_r;
  logic        rvalid;

  modport master (
    output add_w, data_w, wen, wmask, add_r, ren,
    input  wready, data_r, rvalid
  );

  modport slave (
    input  add_w, data_w, wen, wmask, add_r, ren,
    output wready, data_r, rvalid
  );
endinterface

// File: rtl/gpio_ctrl.sv
// Parametrised GPIO controller: direction/output registers with atomic
// set/clear/toggle, synchronised inputs and latched edge interrupts.
`timescale 1ns/1ps

module gpio_ctrl #(
  parameter int NUM_GPIO    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  gpio_ctrl_if.slave          bus,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_oe,
  output logic                irq
);

  typedef logic [NUM_GPIO-1:0] pins_t;

  localparam logic [5:0] REG_OUT    = 6'h00;
  localparam logic [5:0] REG_DIR    = 6'h01;
  localparam logic [5:0] REG_IN     = 6'h02;
  localparam logic [5:0] REG_SET    = 6'h03;
  localparam logic [5:0] REG_CLR    = 6'h04;
  localparam logic [5:0] REG_TGL    = 6'h05;
  localparam logic [5:0] REG_RISE   = 6'h06;
  localparam logic [5:0] REG_FALL   = 6'h07;
  localparam logic [5:0] REG_STATUS = 6'h08;

  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

  pins_t       out_q, dir_q, rise_en_q, fall_en_q, status_q, prev_q;
  pins_t       sync_q [SYNC_STAGES];
  logic [2:0]  warm_cnt;
  logic        wready_q, rvalid_q;
  logic [31:0] data_r_q;

  logic [31:0] byte_mask, wdata_masked, rdata;
  pins_t       wmask_pins, wd, in_sync, events, w1c, out_d, status_d;
  logic [5:0]  waddr, raddr;
  logic        warm_done;
  logic        unused_bits;

  assign in_sync   = sync_q[SYNC_STAGES-1];
  assign waddr     = bus.add_w[7:2];
  assign raddr     = bus.add_r[7:2];
  assign warm_done = (warm_cnt == WARM_DONE);

  // Byte enables gate the write data for every register kind, including W1C.
  always_comb begin
    byte_mask    = {{8{bus.wmask[3]}}, {8{bus.wmask[2]}},
                    {8{bus.wmask[1]}}, {8{bus.wmask[0]}}};
    wdata_masked = bus.data_w & byte_mask;
    wmask_pins   = byte_mask[NUM_GPIO-1:0];
    wd           = wdata_masked[NUM_GPIO-1:0];

    events = '0;
    if (warm_done)
      events = (in_sync & ~prev_q & rise_en_q) | (~in_sync & prev_q & fall_en_q);

    w1c = '0;
    if (bus.wen && waddr == REG_STATUS)
      w1c = wd;
    status_d = (status_q & ~w1c) | events;

    out_d = out_q;
    if (bus.wen) begin
      case (waddr)
        REG_OUT: out_d = (out_q & ~wmask_pins) | wd;
        REG_SET: out_d = out_q | wd;
        REG_CLR: out_d = out_q & ~wd;
        REG_TGL: out_d = out_q ^ wd;
        default: out_d = out_q;
      endcase
    end

    case (raddr)
      REG_OUT:    rdata = 32'(out_q);
      REG_DIR:    rdata = 32'(dir_q);
      REG_IN:     rdata = 32'(in_sync);
      REG_RISE:   rdata = 32'(rise_en_q);
      REG_FALL:   rdata = 32'(fall_en_q);
      REG_STATUS: rdata = 32'(status_q);
      default:    rdata = '0;
    endcase
  end

  assign unused_bits = ^{bus.add_w[31:8], bus.add_w[1:0], bus.add_r[31:8],
                         bus.add_r[1:0], byte_mask, wdata_masked};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  // Reads sample the pre-write register contents, so a same-cycle write is not visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      prev_q    <= '0;
      warm_cnt  <= '0;
      irq       <= 1'b0;
      wready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      data_r_q  <= '0;
    end else begin
      wready_q <= bus.wen;
      rvalid_q <= bus.ren;
      if (bus.ren)
        data_r_q <= rdata;
      out_q <= out_d;
      if (bus.wen && waddr == REG_DIR)
        dir_q <= (dir_q & ~wmask_pins) | wd;
      if (bus.wen && waddr == REG_RISE)
        rise_en_q <= (rise_en_q & ~wmask_pins) | wd;
      if (bus.wen && waddr == REG_FALL)
        fall_en_q <= (fall_en_q & ~wmask_pins) | wd;
      status_q <= status_d;
      irq      <= |status_q;
      prev_q   <= in_sync;
      if (!warm_done)
        warm_cnt <= warm_cnt + 3'd1;
    end
  end

  assign gpio_out   = out_q;
  assign gpio_oe    = dir_q;
  assign bus.wready = wready_q;
  assign bus.rvalid = rvalid_q;
  assign bus.data_r = data_r_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed steps plus a random phase, all
// compared against a delay-line reference model every cycle.
`timescale 1ns/1ps

module tb_gpio_ctrl;

  localparam int          N     = 16;
  localparam int          S     = 2;
  localparam logic [31:0] VMASK = 32'h0000FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  gpio_in;
  logic [N-1:0]  gpio_out, gpio_oe;
  logic          irq;
  logic [4:0]    gpio_in5, gpio_out5, gpio_oe5;
  logic          irq5;

  int errors = 0;
  int checks = 0;

  gpio_ctrl_if bus ();
  gpio_ctrl_if bus5 ();

  gpio_ctrl #(.NUM_GPIO(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  gpio_ctrl #(.NUM_GPIO(5), .SYNC_STAGES(S)) dut5 (
    .clk(clk), .rst(rst), .bus(bus5),
    .gpio_in(gpio_in5), .gpio_out(gpio_out5), .gpio_oe(gpio_oe5), .irq(irq5)
  );

  always #5 clk = ~clk;

  // Reference model: register values as plain words, the synchroniser as a
  // history of per-edge input samples (IN = sample S-1 edges back).
  logic [31:0] m_out, m_dir, m_rise, m_fall, m_status, m_data_r;
  logic        m_irq, m_wready, m_rvalid;
  logic [31:0] hist [$];
  int          m_edges;

  task automatic model_reset();
    m_out = 0; m_dir = 0; m_rise = 0; m_fall = 0; m_status = 0; m_data_r = 0;
    m_irq = 0; m_wready = 0; m_rvalid = 0; m_edges = 0;
    hist.delete();
    for (int i = 0; i <= S; i++) hist.push_back(32'h0);
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    case (addr[7:2])
      6'h00:   return m_out;
      6'h01:   return m_dir;
      6'h02:   return hist[S-1];
      6'h06:   return m_rise;
      6'h07:   return m_fall;
      6'h08:   return m_status;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] in_now, prev, ev, bm, wd, w1c;
    in_now = hist[S-1];
    prev   = hist[S];
    ev     = 0;
    if (m_edges >= S + 1)
      ev = (in_now & ~prev & m_rise) | (~in_now & prev & m_fall);
    bm = {{8{bus.wmask[3]}}, {8{bus.wmask[2]}}, {8{bus.wmask[1]}}, {8{bus.wmask[0]}}} & VMASK;
    wd = bus.data_w & bm;
    m_irq    = (m_status != 0);
    m_rvalid = bus.ren;
    if (bus.ren) m_data_r = model_read(bus.add_r);
    m_wready = bus.wen;
    w1c = (bus.wen && bus.add_w[7:2] == 6'h08) ? wd : 32'h0;
    m_status = (m_status & ~w1c) | ev;
    if (bus.wen) begin
      case (bus.add_w[7:2])
        6'h00: m_out  = (m_out & ~bm) | wd;
        6'h01: m_dir  = (m_dir & ~bm) | wd;
        6'h03: m_out  = m_out | wd;
        6'h04: m_out  = m_out & ~wd;
        6'h05: m_out  = m_out ^ wd;
        6'h06: m_rise = (m_rise & ~bm) | wd;
        6'h07: m_fall = (m_fall & ~bm) | wd;
        default: ;
      endcase
    end
    hist.push_front({16'h0, gpio_in});
    void'(hist.pop_back());
    if (m_edges < 1000) m_edges++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
  endtask

  task automatic check_all();
    checkOutput("gpio_out", {16'h0, gpio_out}, m_out);
    checkOutput("gpio_oe",  {16'h0, gpio_oe},  m_dir);
    checkOutput("irq",      {31'h0, irq},      {31'h0, m_irq});
    checkOutput("wready",   {31'h0, bus.wready}, {31'h0, m_wready});
    checkOutput("rvalid",   {31'h0, bus.rvalid}, {31'h0, m_rvalid});
    checkOutput("data_r",   bus.data_r, m_data_r);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    check_all();
  endtask

  task automatic applyStimulus(input bit w, input logic [31:0] wa, input logic [31:0] wdat,
                               input logic [3:0] wm, input bit r, input logic [31:0] ra);
    bus.wen = w; bus.add_w = wa; bus.data_w = wdat; bus.wmask = wm;
    bus.ren = r; bus.add_r = ra;
    tick();
    bus.wen = 1'b0; bus.ren = 1'b0;
  endtask

  task automatic writeReg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    applyStimulus(1'b1, a, d, m, 1'b0, 32'h0);
  endtask

  task automatic readReg(input logic [31:0] a, input logic [31:0] expected, input string tag);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a);
    checkOutput({tag, "_rvalid"}, {31'h0, bus.rvalid}, 32'h1);
    checkOutput(tag, bus.data_r, expected);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.wen = 0; bus.ren = 0; bus.add_w = 0; bus.add_r = 0; bus.data_w = 0; bus.wmask = 0;
    bus5.wen = 0; bus5.ren = 0; bus5.add_w = 0; bus5.add_r = 0; bus5.data_w = 0; bus5.wmask = 0;
    gpio_in  = '1;
    gpio_in5 = '0;
    model_reset();

    $display("[TB] reset with all inputs high");
    #2 rst = 1'b1;
    #1 check_all();
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    writeReg(32'h18, 32'hFFFF, 4'hF);
    repeat (6) tick();
    readReg(32'h20, 32'h0, "warmup_status");
    checkOutput("warmup_irq", {31'h0, irq}, 32'h0);
    readReg(32'h08, 32'hFFFF, "in_all_ones");
    writeReg(32'h18, 32'h0, 4'hF);
    gpio_in = '0;
    repeat (4) tick();

    $display("[TB] reset mid-transfer");
    writeReg(32'h00, 32'hFFFF, 4'hF);
    writeReg(32'h04, 32'h00FF, 4'hF);
    bus.wen = 1; bus.add_w = 32'h0; bus.data_w = 32'h55; bus.wmask = 4'hF;
    bus.ren = 1; bus.add_r = 32'h0;
    @(posedge clk);
    model_step();
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    checkOutput("rst_gpio_out", {16'h0, gpio_out}, 32'h0);
    checkOutput("rst_gpio_oe", {16'h0, gpio_oe}, 32'h0);
    checkOutput("rst_wready", {31'h0, bus.wready}, 32'h0);
    checkOutput("rst_rvalid", {31'h0, bus.rvalid}, 32'h0);
    bus.wen = 0; bus.ren = 0;
    @(posedge clk); #1 rst = 1'b0;
    for (int a = 0; a <= 32'h20; a += 4)
      readReg(32'(a), 32'h0, "rst_reg");
    readReg(32'h3C, 32'h0, "rst_unmapped");

    $display("[TB] RW and byte masking");
    writeReg(32'h00, 32'h0000A5A5, 4'b0001);
    checkOutput("mask_wready", {31'h0, bus.wready}, 32'h1);
    readReg(32'h00, 32'h000000A5, "mask_out");
    checkOutput("mask_gpio_out", {16'h0, gpio_out}, 32'h00A5);
    writeReg(32'h04, 32'h0000C30F, 4'b0011);
    checkOutput("dir_gpio_oe", {16'h0, gpio_oe}, 32'hC30F);

    $display("[TB] atomic set/clear/toggle back to back");
    writeReg(32'h00, 32'h00F0, 4'hF);
    writeReg(32'h0C, 32'h000F, 4'hF);
    checkOutput("set_wready", {31'h0, bus.wready}, 32'h1);
    checkOutput("set_out", {16'h0, gpio_out}, 32'h00FF);
    writeReg(32'h10, 32'h0081, 4'hF);
    checkOutput("clr_wready", {31'h0, bus.wready}, 32'h1);
    checkOutput("clr_out", {16'h0, gpio_out}, 32'h007E);
    writeReg(32'h14, 32'hFFFF, 4'hF);
    checkOutput("tgl_wready", {31'h0, bus.wready}, 32'h1);
    checkOutput("tgl_out", {16'h0, gpio_out}, 32'hFF81);
    tick();
    checkOutput("atomic_wready_end", {31'h0, bus.wready}, 32'h0);
    readReg(32'h0C, 32'h0, "set_reads_zero");
    writeReg(32'h10, 32'h0001, 4'h0);
    checkOutput("nomask_out", {16'h0, gpio_out}, 32'hFF81);

    $display("[TB] edge interrupts");
    gpio_in = 16'h0002;
    repeat (5) tick();
    writeReg(32'h18, 32'h0001, 4'hF);
    writeReg(32'h1C, 32'h0002, 4'hF);
    writeReg(32'h20, 32'hFFFF, 4'hF);
    gpio_in = 16'h0001;
    tick();
    repeat (S - 1) tick();
    tick();
    checkOutput("irq_not_yet", {31'h0, irq}, 32'h0);
    readReg(32'h20, 32'h3, "irq_status");
    checkOutput("irq_asserted", {31'h0, irq}, 32'h1);
    writeReg(32'h20, 32'h1, 4'hF);
    readReg(32'h20, 32'h2, "w1c_status");
    checkOutput("irq_still", {31'h0, irq}, 32'h1);
    writeReg(32'h20, 32'h2, 4'hF);
    checkOutput("irq_lag", {31'h0, irq}, 32'h1);
    tick();
    checkOutput("irq_cleared", {31'h0, irq}, 32'h0);

    $display("[TB] set wins over W1C");
    gpio_in = 16'h0000;
    repeat (5) tick();
    writeReg(32'h20, 32'hFFFF, 4'hF);
    gpio_in = 16'h0001;
    tick();
    repeat (S - 1) tick();
    writeReg(32'h20, 32'h1, 4'hF);
    readReg(32'h20, 32'h1, "set_wins");
    writeReg(32'h18, 32'h0, 4'hF);
    readReg(32'h20, 32'h1, "status_kept");
    writeReg(32'h20, 32'h1, 4'hF);

    $display("[TB] read/write collision and unmapped");
    writeReg(32'h00, 32'h1234, 4'hF);
    applyStimulus(1'b1, 32'h00, 32'h5678, 4'hF, 1'b1, 32'h00);
    checkOutput("collide_old", bus.data_r, 32'h1234);
    readReg(32'h00, 32'h5678, "collide_new");
    readReg(32'h3C, 32'h0, "unmapped_read");
    writeReg(32'h3C, 32'hFFFF, 4'hF);
    checkOutput("unmapped_wready", {31'h0, bus.wready}, 32'h1);
    readReg(32'h100, 32'h5678, "alias_read");

    $display("[TB] NUM_GPIO=5 instance");
    bus5.wen = 1; bus5.add_w = 32'h0; bus5.data_w = 32'hFFFFFFFF; bus5.wmask = 4'hF;
    tick();
    bus5.wen = 0;
    checkOutput("n5_wready", {31'h0, bus5.wready}, 32'h1);
    bus5.ren = 1; bus5.add_r = 32'h0;
    tick();
    bus5.ren = 0;
    checkOutput("n5_rvalid", {31'h0, bus5.rvalid}, 32'h1);
    checkOutput("n5_read", bus5.data_r, 32'h0000001F);
    checkOutput("n5_gpio_out", {27'h0, gpio_out5}, 32'h1F);

    $display("[TB] random phase");
    for (int i = 0; i < 400; i++) begin
      int wo, ro;
      wo = $urandom_range(0, 9); if (wo == 9) wo = 15;
      ro = $urandom_range(0, 9); if (ro == 9) ro = 15;
      if ($urandom_range(0, 3) == 0)
        gpio_in = gpio_in ^ N'(1 << $urandom_range(0, N - 1));
      applyStimulus(1'($urandom_range(0, 1)), 32'(wo * 4), $urandom(),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 32'(ro * 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
